mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (port I, read-only) and load/store (port D, read/write).
- Owns the shared-port select. It sequences each transaction with a req/ack handshake and resolves contention round-robin.
- Sits between the fetch/LSU stages and the unified memory interface. It drives the select of the 2:1 address/data steering muxes.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits (multiple of 8)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- i_req  input  1  fetch request; held high with stable i_addr until i_ack
- i_addr  input  AW  fetch address
- i_ack  output  1  fetch complete; one-cycle pulse; i_rdata valid this cycle
- i_rdata  output  DW  fetch read data
- d_req  input  1  data request; held high with stable d_* until d_ack
- d_we  input  1  1 = write, 0 = read
- d_addr  input  AW  data address
- d_wdata  input  DW  write data
- d_be  input  DW/8  byte enables (writes only)
- d_ack  output  1  data complete; one-cycle pulse; d_rdata valid on reads
- d_rdata  output  DW  data read data
- mem_sel  output  1  current owner: 0 = fetch, 1 = data (registered)
- mem_req  output  1  shared-port request
- mem_we  output  1  shared-port write enable
- mem_addr  output  AW  shared-port address
- mem_wdata  output  DW  shared-port write data
- mem_be  output  DW/8  shared-port byte enables
- mem_ack  input  1  memory completion; one-cycle pulse; may arrive in the first cycle mem_req is high
- mem_rdata  input  DW  memory read data, valid with mem_ack

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. State, mem_sel and last-served pointer last_d are registered. All are cleared asynchronously by rst: state = IDLE, mem_sel = 0, last_d = 1 (so fetch wins the first tie).
- Reset values of outputs (combinational from reset state): mem_req = 0, mem_we = 0, mem_be = 0, i_ack = 0, d_ack = 0. mem_addr = i_addr, mem_wdata = d_wdata, i_rdata = d_rdata = mem_rdata.
- mem_req = 1 exactly in BUSY_I or BUSY_D.
- Steering is always driven by mem_sel:
  - mem_addr = mem_sel ? d_addr : i_addr.
  - mem_wdata = d_wdata.
  - mem_we = BUSY_D & d_we. mem_be = BUSY_D ? d_be : 0. mem_we and mem_be are 0 in BUSY_I and IDLE.
- Acks are combinational pass-through: i_ack = BUSY_I & mem_ack; d_ack = BUSY_D & mem_ack. mem_ack in IDLE is ignored.
- Read data passes through: i_rdata = d_rdata = mem_rdata. Only the acked port may consume it.
- IDLE transitions:
  - Only i_req → BUSY_I, mem_sel <= 0.
  - Only d_req → BUSY_D, mem_sel <= 1.
  - Both → grant the port not last served: last_d = 1 → BUSY_I, else BUSY_D.
  - Neither → stay in IDLE.
- BUSY_x without mem_ack: hold state and mem_sel. The grant is never preempted.
- BUSY_x with mem_ack:
  - last_d <= (x == D).
  - If the other port's req is high → go directly to BUSY_other, mem_sel updated, no idle bubble.
  - Otherwise → IDLE.
  - The just-acked port's req is ignored in that cycle, since the requester drops it after seeing ack.
- Latency:
  - req rises in cycle n (from IDLE) → mem_req high from cycle n+1.
  - Earliest ack is in cycle n+1.
  - Back-to-back alternating transactions are sustained with zero dead cycles.
- Fairness: with both ports continuously requesting, grants strictly alternate I, D, I, D. No port waits more than one foreign transaction.
- Requester protocol violations are undefined: dropping req or changing address/data before ack.
- Reset mid-transaction:
  - State goes to IDLE and mem_req drops immediately (asynchronously).
  - No ack is issued for the abandoned transaction.
  - The memory controller must discard any in-flight access on rst.

Test Plan:
- Reset: assert rst mid-BUSY_D with d_we = 1 → mem_req, mem_we, mem_be, d_ack drop in the same cycle; mem_sel = 0. After release with i_req = d_req = 1 → BUSY_I granted first.
- Single fetch: i_req = 1, i_addr = 0x0000_0040; memory acks two cycles after mem_req with rdata 0x0010_0093 → mem_addr = 0x40, mem_we = 0, i_ack pulses once with i_rdata = 0x0010_0093, then IDLE.
- Data write: d_req = 1, d_we = 1, d_addr = 0x1000_0004, d_wdata = 0xDEAD_BEEF, d_be = 0b1100 → mem_sel = 1, mem_we = 1, mem_be = 0b1100, mem_wdata = 0xDEADBEEF; d_ack on mem_ack; i_ack stays 0.
- Contention: i_req and d_req held high, zero-wait memory (mem_ack = mem_req) → grants I, D, I, D on consecutive cycles. mem_sel toggles every cycle; mem_req stays continuously high.
- Hold: mem_ack withheld 5 cycles during BUSY_I while d_req rises → mem_sel stays 0, mem_addr stays i_addr. Switch to D occurs the cycle after the ack.
- Spurious ack: pulse mem_ack in IDLE → no i_ack or d_ack, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between fetch/LSU requesters, the arbiter and the shared memory port
//
// Signals:
//   i_req/i_addr            -> fetch request (read-only)
//   i_ack/i_rdata           <- fetch completion and read data
//   d_req/d_we/d_addr/
//   d_wdata/d_be            -> load/store request
//   d_ack/d_rdata           <- load/store completion and read data
//   mem_sel                 <- current owner of the shared port (0 = fetch, 1 = data)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be        <- shared memory port request
//   mem_ack/mem_rdata       -> shared memory port completion and read data
// Modports:
//   master - the arbiter, which masters the shared memory port
//   slave  - the surrounding fetch stage, LSU and memory controller
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              i_req;
  logic [AW-1:0]     i_addr;
  logic              i_ack;
  logic [DW-1:0]     i_rdata;

  logic              d_req;
  logic              d_we;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_wdata;
  logic [DW/8-1:0]   d_be;
  logic              d_ack;
  logic [DW-1:0]     d_rdata;

  logic              mem_sel;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_be;
  logic              mem_ack;
  logic [DW-1:0]     mem_rdata;

  modport master (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ack, d_rdata,
    output mem_sel, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ack, d_rdata,
    input  mem_sel, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mem_port_arbiter_if.master: fetch port (i_*), data port (d_*),
//          steering select (mem_sel) and shared memory port (mem_*)
// Widths (AW, DW) are taken from the interface instance.
module mem_port_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   mem_sel_q, mem_sel_d;
  // 1 when the data port was served most recently; resets to 1 so fetch wins the first tie.
  logic   last_d_q, last_d_d;

  logic   busy_i;
  logic   busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_sel_q <= 1'b0;
      last_d_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      mem_sel_q <= mem_sel_d;
      last_d_q  <= last_d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_sel_d = mem_sel_q;
    last_d_d  = last_d_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req && bus.d_req) begin
          if (last_d_q) begin
            state_d   = BUSY_I;
            mem_sel_d = 1'b0;
          end else begin
            state_d   = BUSY_D;
            mem_sel_d = 1'b1;
          end
        end else if (bus.i_req) begin
          state_d   = BUSY_I;
          mem_sel_d = 1'b0;
        end else if (bus.d_req) begin
          state_d   = BUSY_D;
          mem_sel_d = 1'b1;
        end
      end
      BUSY_I: begin
        // The just-acked fetch req is ignored: the requester drops it after seeing i_ack.
        if (bus.mem_ack) begin
          last_d_d = 1'b0;
          if (bus.d_req) begin
            state_d   = BUSY_D;
            mem_sel_d = 1'b1;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          last_d_d = 1'b1;
          if (bus.i_req) begin
            state_d   = BUSY_I;
            mem_sel_d = 1'b0;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_i = (state_q == BUSY_I);
  assign busy_d = (state_q == BUSY_D);

  // Steering follows the registered select even when idle, so the muxes never glitch on req.
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_req   = busy_i | busy_d;
  assign bus.mem_we    = busy_d & bus.d_we;
  assign bus.mem_addr  = mem_sel_q ? bus.d_addr : bus.i_addr;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.mem_be    = busy_d ? bus.d_be : '0;

  // Acks pass straight through so a zero-wait memory completes in the grant cycle.
  assign bus.i_ack   = busy_i & bus.mem_ack;
  assign bus.d_ack   = busy_d & bus.mem_ack;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule
